// File: rtl/counter_mode_ctrl_pkg.sv
// Shared mode encodings and LED constants for the counter mode controller.
// The mode values double as the counter's 2-bit mode select.
package counter_mode_ctrl_pkg;

    localparam logic [1:0] MODE_UP   = 2'd0;
    localparam logic [1:0] MODE_DN   = 2'd1;
    localparam logic [1:0] MODE_HOLD = 2'd2;
    localparam logic [1:0] MODE_CLR  = 2'd3;

    typedef enum logic [1:0] {
        ST_UP   = MODE_UP,
        ST_DN   = MODE_DN,
        ST_HOLD = MODE_HOLD,
        ST_CLR  = MODE_CLR
    } mode_e;

    localparam logic [3:0] LED_UP   = 4'b0001;
    localparam logic [3:0] LED_DN   = 4'b0010;
    localparam logic [3:0] LED_HOLD = 4'b0100;
    localparam logic [3:0] LED_CLR  = 4'b1000;

    // Button bit positions line up with LED bits so one index serves both.
    localparam int BTN_UP_IDX   = 0;
    localparam int BTN_DN_IDX   = 1;
    localparam int BTN_HOLD_IDX = 2;
    localparam int BTN_CLR_IDX  = 3;

    function automatic logic [3:0] mode_led(input mode_e m);
        logic [3:0] v;
        case (m)
            ST_UP:   v = LED_UP;
            ST_DN:   v = LED_DN;
            ST_HOLD: v = LED_HOLD;
            default: v = LED_CLR;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/counter_mode_ctrl_btn_debounce.sv
// One push-button front end: 2-FF synchroniser, run-length debounce and
// rising-edge press detector. Releases are debounced but never reported.
module btn_debounce
    import counter_mode_ctrl_pkg::*;
#(
    parameter int DB_W   = 16,
    parameter int DB_LIM = 50000
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_btn,
    output logic o_deb,
    output logic o_press
);

    localparam logic [DB_W-1:0] CNT_MAX = DB_W'(DB_LIM - 1);

    logic            r_sy1;
    logic            r_sy2;
    logic            r_deb;
    logic            r_deb_d;
    logic [DB_W-1:0] r_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sy1   <= 1'b0;
            r_sy2   <= 1'b0;
            r_deb   <= 1'b0;
            r_deb_d <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sy1   <= i_btn;
            r_sy2   <= r_sy1;
            r_deb_d <= r_deb;
            // Any sample agreeing with the accepted level restarts the run.
            if (r_sy2 == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_deb <= r_sy2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_deb   = r_deb;
    assign o_press = r_deb & ~r_deb_d;

endmodule

// File: rtl/counter_mode_ctrl.sv
// Mode state machine for the up/down/hold/clear counter, fed by four
// debounced push-buttons. s is the registered mode select for the counter.
module counter_mode_ctrl
    import counter_mode_ctrl_pkg::*;
#(
    parameter int DB_W   = 16,
    parameter int DB_LIM = 50000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN_UP,
    input  logic       BTN_DN,
    input  logic       BTN_HOLD,
    input  logic       BTN_CLR,
    output logic [1:0] s,
    output logic [3:0] led,
    output logic       mode_chg
);

    logic [3:0] w_btn;
    logic [3:0] w_deb;
    logic [3:0] w_press;
    logic       w_unused;
    mode_e      r_state;
    mode_e      w_nxt;

    assign w_btn = {BTN_CLR, BTN_HOLD, BTN_DN, BTN_UP};

    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
        btn_debounce #(
            .DB_W   (DB_W),
            .DB_LIM (DB_LIM)
        ) u_db (
            .CLK     (CLK),
            .RST     (RST),
            .i_btn   (w_btn[gi]),
            .o_deb   (w_deb[gi]),
            .o_press (w_press[gi])
        );
    end

    // Debounced levels are not needed here; only the press strobes steer the FSM.
    assign w_unused = ^w_deb;

    // CLEAR is transient: it falls back to HOLD unless a press overrides it.
    always_comb begin
        w_nxt = r_state;
        if (r_state == ST_CLR) w_nxt = ST_HOLD;
        if (w_press[BTN_CLR_IDX])       w_nxt = ST_CLR;
        else if (w_press[BTN_HOLD_IDX]) w_nxt = ST_HOLD;
        else if (w_press[BTN_DN_IDX])   w_nxt = ST_DN;
        else if (w_press[BTN_UP_IDX])   w_nxt = ST_UP;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= ST_HOLD;
            led      <= LED_HOLD;
            mode_chg <= 1'b0;
        end else begin
            r_state  <= w_nxt;
            led      <= mode_led(w_nxt);
            mode_chg <= (w_nxt != r_state);
        end
    end

    assign s = r_state;

endmodule

// File: tb/tb_counter_mode_ctrl.sv
// Self-checking bench for counter_mode_ctrl with a short debounce window.
module tb_counter_mode_ctrl;

    localparam int DB_W   = 4;
    localparam int DB_LIM = 4;
    localparam int SETTLE = 10;
    localparam int NVEC   = 14;

    localparam logic [3:0] B_UP   = 4'b0001;
    localparam logic [3:0] B_DN   = 4'b0010;
    localparam logic [3:0] B_HOLD = 4'b0100;
    localparam logic [3:0] B_CLR  = 4'b1000;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       BTN_UP = 1'b0, BTN_DN = 1'b0, BTN_HOLD = 1'b0, BTN_CLR = 1'b0;
    logic [1:0] s;
    logic [3:0] led;
    logic       mode_chg;

    typedef struct {
        logic [3:0] b0;
        logic [3:0] b;
        int         cyc;
        logic [1:0] s;
        logic [3:0] led;
        int         chg;
    } vec_t;

    typedef struct {
        logic [1:0] s;
        logic [3:0] led;
        int         chg;
    } exp_t;

    vec_t vt [NVEC];
    exp_t sb [$];

    int n_chk = 0;
    int n_fail = 0;
    int chg_total = 0;

    always #5 CLK = ~CLK;

    counter_mode_ctrl #(.DB_W(DB_W), .DB_LIM(DB_LIM)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .BTN_UP   (BTN_UP),
        .BTN_DN   (BTN_DN),
        .BTN_HOLD (BTN_HOLD),
        .BTN_CLR  (BTN_CLR),
        .s        (s),
        .led      (led),
        .mode_chg (mode_chg)
    );

    always @(negedge CLK) if (mode_chg === 1'b1) chg_total++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_btn(input logic [3:0] b);
        {BTN_CLR, BTN_HOLD, BTN_DN, BTN_UP} = b;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   base;
        exp_t e;

        vt[0]  = '{B_DN,          B_DN,          3, 2'd2, 4'b0100, 0};
        vt[1]  = '{B_DN,          B_DN,          5, 2'd1, 4'b0010, 1};
        vt[2]  = '{B_HOLD,        B_HOLD,        4, 2'd2, 4'b0100, 1};
        vt[3]  = '{B_UP|B_DN,     B_UP|B_DN,     5, 2'd1, 4'b0010, 1};
        vt[4]  = '{B_DN,          B_DN,          5, 2'd1, 4'b0010, 0};
        vt[5]  = '{B_UP,          B_UP,          3, 2'd1, 4'b0010, 0};
        vt[6]  = '{B_UP,          B_UP,          6, 2'd0, 4'b0001, 1};
        vt[7]  = '{B_CLR|B_HOLD,  B_CLR|B_HOLD,  6, 2'd2, 4'b0100, 2};
        vt[8]  = '{B_HOLD,        B_HOLD,        6, 2'd2, 4'b0100, 0};
        vt[9]  = '{B_CLR,         B_CLR,         6, 2'd2, 4'b0100, 2};
        vt[10] = '{4'b1111,       4'b1111,       6, 2'd2, 4'b0100, 2};
        vt[11] = '{B_UP,          B_UP,          6, 2'd0, 4'b0001, 1};
        vt[12] = '{B_CLR|B_UP,    B_CLR|B_UP,    6, 2'd2, 4'b0100, 2};
        vt[13] = '{B_CLR,         B_CLR|B_UP,    6, 2'd0, 4'b0001, 2};

        // Asynchronous reset before any clock edge
        #1 RST = 1'b1;
        #1;
        check("rst_s", 32'(s), 32'd2);
        check("rst_led", 32'(led), 32'b0100);
        check("rst_chg", 32'(mode_chg), 32'd0);
        tick();
        tick();
        RST = 1'b0;
        repeat (3) tick();
        check("post_rst_s", 32'(s), 32'd2);
        check("post_rst_led", 32'(led), 32'b0100);
        check("post_rst_chg_cnt", 32'(chg_total), 32'd0);

        // UP press latency: s changes exactly DB_LIM+2 edges after edge 0
        base = chg_total;
        set_btn(B_UP);
        repeat (DB_LIM + 2) tick();
        check("up_lat_early_s", 32'(s), 32'd2);
        check("up_lat_early_chg", 32'(mode_chg), 32'd0);
        tick();
        check("up_lat_s", 32'(s), 32'd0);
        check("up_lat_led", 32'(led), 32'b0001);
        check("up_lat_chg", 32'(mode_chg), 32'd1);
        tick();
        check("up_chg_one_cycle", 32'(mode_chg), 32'd0);
        repeat (2) tick();
        set_btn(4'b0000);
        repeat (SETTLE) tick();
        check("up_release_s", 32'(s), 32'd0);
        check("up_chg_cnt", 32'(chg_total - base), 32'd1);

        // CLR from UP: one cycle of CLEAR, then HOLD, two back-to-back pulses
        set_btn(B_CLR);
        repeat (DB_LIM + 2) tick();
        check("clr_before_s", 32'(s), 32'd0);
        tick();
        check("clr_s", 32'(s), 32'd3);
        check("clr_led", 32'(led), 32'b1000);
        check("clr_chg1", 32'(mode_chg), 32'd1);
        tick();
        check("clr_to_hold_s", 32'(s), 32'd2);
        check("clr_to_hold_led", 32'(led), 32'b0100);
        check("clr_chg2", 32'(mode_chg), 32'd1);
        tick();
        check("clr_settled_s", 32'(s), 32'd2);
        check("clr_chg_done", 32'(mode_chg), 32'd0);
        set_btn(4'b0000);
        repeat (SETTLE) tick();

        // Table of press patterns, expected results queued at drive time
        for (int i = 0; i < NVEC; i++) begin
            base = chg_total;
            sb.push_back('{vt[i].s, vt[i].led, vt[i].chg});
            set_btn(vt[i].b0);
            tick();
            set_btn(vt[i].b);
            repeat (vt[i].cyc - 1) tick();
            set_btn(4'b0000);
            repeat (SETTLE) tick();
            e = sb.pop_front();
            check($sformatf("vec%0d_s", i), 32'(s), 32'(e.s));
            check($sformatf("vec%0d_led", i), 32'(led), 32'(e.led));
            check($sformatf("vec%0d_chg", i), 32'(chg_total - base), 32'(e.chg));
        end

        // Reset mid-debounce with the button still held; fresh debounce after release
        set_btn(B_UP);
        repeat (4) tick();
        #2 RST = 1'b1;
        #1;
        check("mid_rst_s", 32'(s), 32'd2);
        check("mid_rst_led", 32'(led), 32'b0100);
        check("mid_rst_chg", 32'(mode_chg), 32'd0);
        tick();
        tick();
        RST = 1'b0;
        base = chg_total;
        repeat (DB_LIM + 2) tick();
        check("rel_early_s", 32'(s), 32'd2);
        check("rel_no_pulse", 32'(chg_total - base), 32'd0);
        tick();
        check("rel_up_s", 32'(s), 32'd0);
        check("rel_up_led", 32'(led), 32'b0001);
        set_btn(4'b0000);
        repeat (SETTLE) tick();
        check("rel_chg_cnt", 32'(chg_total - base), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_mode_ctrl.md
Name: counter_mode_ctrl

Overview:
Upstream control stage for the up/down/hold/clear counter.
- Takes four raw push-buttons, synchronises and debounces them, and detects presses.
- Runs a mode state machine whose registered output s drives the counter's 2-bit mode select directly (0 up, 1 down, 2 hold, 3 clear).
- Also provides one-hot mode LEDs and a mode-change strobe.

Parameters:
DB_W, 16, width of each per-button debounce counter
DB_LIM, 50000, consecutive stable samples required to accept a new level (2 ≤ DB_LIM ≤ 2^DB_W−1)

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous, active-high reset
BTN_UP  in  1  raw button, active high, asynchronous to CLK
BTN_DN  in  1  raw button, active high, asynchronous
BTN_HOLD  in  1  raw button, active high, asynchronous
BTN_CLR  in  1  raw button, active high, asynchronous
s  out  2  registered counter mode select (0 up, 1 down, 2 hold, 3 clear)
led  out  4  one-hot mode indicator: [0] up, [1] down, [2] hold, [3] clear
mode_chg  out  1  one-cycle pulse, high in the cycle after s changes value

Behaviour:
Reset values (all registers reset asynchronously):
- s=2 (HOLD), led=4'b0100, mode_chg=0.
- All synchroniser, debounce-counter, debounced-level and delayed-level registers = 0.

Per button:
- 2-FF synchroniser: sy1 <= BTN; sy2 <= sy1.
- Debounce, with debounced level deb and counter cnt:
  - if sy2==deb: cnt<=0
  - else if cnt==DB_LIM−1: deb<=sy2, cnt<=0
  - else: cnt<=cnt+1
- Any mismatch run shorter than DB_LIM cycles is discarded. A glitch resets cnt to 0.
- deb_d <= deb. press = deb & ~deb_d (combinational, one cycle wide). Releases produce nothing.

Latency:
- Edge 0 is the first CLK edge that samples the button high. Input held high from edge 0.
- deb rises at edge DB_LIM+1.
- s takes its new value at edge DB_LIM+2.
- mode_chg is high for the cycle following edge DB_LIM+2.

Mode FSM (state register is s):
- Press priority when several presses occur in the same cycle: CLR > HOLD > DN > UP.
- In UP, DOWN or HOLD:
  - winning press CLR → CLEAR
  - winning press HOLD → HOLD
  - winning press DN → DOWN
  - winning press UP → UP
  - no press → stay
- CLEAR lasts exactly one cycle. Next state is the winning press target if a press occurs in that cycle, otherwise HOLD. A CLR press in that cycle keeps CLEAR for one more cycle.
- Press targeting the current state: no state change and no mode_chg.
- mode_chg <= (next_state != s), registered on the same edge as s.
  - Consequence: a CLR press from UP gives two mode_chg pulses (into CLEAR, then into HOLD).
- led is registered and always the one-hot decode of s. It never shows zero or multiple bits.

Boundary conditions:
- Button held through reset release: deb restarts at 0, so the held level is debounced afresh and yields a press DB_LIM+2 edges after the first post-release edge.
- Reset asserted mid-debounce or mid-CLEAR: outputs go to reset values immediately, without waiting for a clock edge. No pulse is emitted on release.
- cnt never exceeds DB_LIM−1. No wrap.

Decomposition:
Shared package holds:
- Mode encodings MODE_UP=2'd0, MODE_DN=2'd1, MODE_HOLD=2'd2, MODE_CLR=2'd3. These are shared with the counter's mode input.
- LED one-hot constants.

Natural sub-module: btn_debounce.
- Parameters DB_W and DB_LIM.
- Contains the synchroniser, debounce counter and press detector.
- Outputs deb and press.
- Instantiated four times. The top level holds only the FSM, priority logic and LED decode.

Test Plan (DB_LIM=4, DB_W=4):
1. Reset: RST=1 → s=2, led=0100, mode_chg=0 asynchronously, before any clock edge. Release → values hold.
2. BTN_UP high from edge 0 for 10 cycles → s=0 at edge 6, led=0001, mode_chg high exactly one cycle. Release → no further change.
3. Glitch: BTN_DN high for 3 cycles, then low → s stays 2 and mode_chg never asserts. Repeat with a 5-cycle pulse → s=1.
4. From UP, press BTN_CLR → s=3 for exactly one cycle, then s=2. mode_chg pulses twice on consecutive cycles. led steps 0001→1000→0100.
5. From HOLD, BTN_UP and BTN_DN rise on the same edge → s=1 (DN wins). Then BTN_DN pressed again → no mode_chg.
6. BTN_UP held and RST pulsed at edge 3 of debounce → s=2 immediately. After release, s=0 six edges after the first post-release edge.
